// File: rtl/cpu_bus_responder_pkg.sv
// Shared constants for the Taito F2 CPU bus: chip-select region order and bus FSM states.
package system_consts;

  localparam int REGION_W = 4;

  typedef enum logic [REGION_W-1:0] {
    CS_WORK      = 4'd0,
    CS_ROM       = 4'd1,
    CS_SCREEN    = 4'd2,
    CS_COLOR     = 4'd3,
    CS_IO0       = 4'd4,
    CS_IO1       = 4'd5,
    CS_OBJECT    = 4'd6,
    CS_SOUND     = 4'd7,
    CS_PRIORITY  = 4'd8,
    CS_EXTENSION = 4'd9,
    CS_CCHIP     = 4'd10
  } region_e;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_WAIT,
    BUS_EXT,
    BUS_ACK,
    BUS_ERR
  } bus_state_e;

  localparam logic [REGION_W-1:0] CS_ROM_IDX = CS_ROM;

endpackage

// File: rtl/cpu_bus_responder_cs_priority_encoder.sv
// Finds the lowest-index asserted (low) chip select; valid is low when none is asserted.
import system_consts::*;

module cs_priority_encoder #(
  parameter int N_CS = 11
) (
  input  logic [N_CS-1:0]     cs_n,
  output logic [REGION_W-1:0] idx,
  output logic                valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downward so the lowest asserted index is written last and wins.
    for (int i = N_CS - 1; i >= 0; i--) begin
      if (!cs_n[i]) begin
        idx   = REGION_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// 68000 bus responder: per-region wait states, SDRAM ROM handshake, DTACK/BERR generation.
// Optional bus watchdog and unmapped-access bus error enabled by defining BUS_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   BUS_IDLE | waiting for AS/DS with cpu_ce; latches region and wait count
//   BUS_WAIT | counting down wait states on cpu_ce
//   BUS_EXT  | rom_req high, waiting for rom_ack from the SDRAM port
//   BUS_ACK  | DTACK asserted until AS is released
//   BUS_ERR  | BERR asserted until AS is released (BUS_TIMEOUT_EN only)
import system_consts::*;

module cpu_bus_responder #(
  parameter int N_CS    = 11,
  parameter int WS_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_ce,
  input  logic                 cpu_as_n,
  input  logic [1:0]           cpu_ds_n,
  input  logic [N_CS-1:0]      cs_n,
  input  logic [N_CS*WS_W-1:0] cfg_wait,
  output logic                 rom_req,
  input  logic                 rom_ack,
  output logic                 cpu_dtack_n,
  output logic                 cpu_berr_n,
  output logic [3:0]           active_region
);

  bus_state_e          state, next_state;
  logic [WS_W-1:0]     wait_cnt;
  logic [REGION_W-1:0] region_q;
  logic                unmapped_q;

  logic [REGION_W-1:0] enc_idx;
  logic                enc_valid;
  logic [WS_W-1:0]     sel_wait;
  logic                cycle_start;
  logic                wd_expire;

  cs_priority_encoder #(.N_CS(N_CS)) u_cs_enc (
    .cs_n  (cs_n),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign cycle_start = cpu_ce && !cpu_as_n && (cpu_ds_n != 2'b11);
  assign sel_wait    = enc_valid ? cfg_wait[enc_idx*WS_W +: WS_W] : '0;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wd_cnt;

  assign wd_expire = cpu_ce && (wd_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == BUS_WAIT || state == BUS_EXT) begin
      if (cpu_ce) wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  logic unused_timeout;
  assign wd_expire      = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BUS_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      BUS_IDLE: begin
        if (cycle_start) begin
          if (!enc_valid) begin
`ifdef BUS_TIMEOUT_EN
            next_state = BUS_WAIT;
`else
            next_state = BUS_ACK;
`endif
          end else if (sel_wait != '0) begin
            next_state = BUS_WAIT;
          end else if (enc_idx == CS_ROM_IDX) begin
            next_state = BUS_EXT;
          end else begin
            next_state = BUS_ACK;
          end
        end
      end
      BUS_WAIT: begin
        if (cpu_as_n) begin
          next_state = BUS_IDLE;
        end else if (wd_expire) begin
          next_state = BUS_ERR;
        end else if (cpu_ce && !unmapped_q && wait_cnt == WS_W'(1)) begin
          next_state = (region_q == CS_ROM_IDX) ? BUS_EXT : BUS_ACK;
        end
      end
      BUS_EXT: begin
        // Abort wins over a coincident rom_ack.
        if (cpu_as_n)       next_state = BUS_IDLE;
        else if (wd_expire) next_state = BUS_ERR;
        else if (rom_ack)   next_state = BUS_ACK;
      end
      BUS_ACK, BUS_ERR: begin
        if (cpu_as_n) next_state = BUS_IDLE;
      end
      default: next_state = BUS_IDLE;
    endcase
  end

  always_comb begin
    cpu_dtack_n   = (state != BUS_ACK);
    rom_req       = (state == BUS_EXT);
    active_region = region_q;
`ifdef BUS_TIMEOUT_EN
    cpu_berr_n    = (state != BUS_ERR);
`else
    cpu_berr_n    = 1'b1;
`endif
  end

  // Region and wait count are captured once per cycle; later cs_n changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt   <= '0;
      region_q   <= '0;
      unmapped_q <= 1'b0;
    end else if (state == BUS_IDLE && cycle_start) begin
      wait_cnt   <= sel_wait;
      region_q   <= enc_valid ? enc_idx : '0;
      unmapped_q <= !enc_valid;
    end else if (state == BUS_WAIT && cpu_ce && wait_cnt != '0) begin
      wait_cnt   <= wait_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench for cpu_bus_responder; expected latencies/regions go through a scoreboard queue.
`timescale 1ns/1ps

module tb_cpu_bus_responder;

  localparam int N_CS = 11;
  localparam int WS_W = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cpu_ce;
  logic                 cpu_as_n;
  logic [1:0]           cpu_ds_n;
  logic [N_CS-1:0]      cs_n;
  logic [N_CS*WS_W-1:0] cfg_wait;
  logic                 rom_req;
  logic                 rom_ack;
  logic                 cpu_dtack_n;
  logic                 cpu_berr_n;
  logic [3:0]           active_region;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         lat;
    logic [3:0] region;
  } exp_t;
  exp_t sb[$];

  cpu_bus_responder #(.N_CS(N_CS), .WS_W(WS_W), .TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_ce        (cpu_ce),
    .cpu_as_n      (cpu_as_n),
    .cpu_ds_n      (cpu_ds_n),
    .cs_n          (cs_n),
    .cfg_wait      (cfg_wait),
    .rom_req       (rom_req),
    .rom_ack       (rom_ack),
    .cpu_dtack_n   (cpu_dtack_n),
    .cpu_berr_n    (cpu_berr_n),
    .active_region (active_region)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic clk_step(input logic ce_v);
    cpu_ce = ce_v;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wait(input int idx, input logic [3:0] val);
    cfg_wait[idx*WS_W +: WS_W] = val;
  endtask

  task automatic end_cycle();
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    cs_n     = '1;
    clk_step(1'b0);
    n_checks++;
    if (cpu_dtack_n !== 1'b1) begin
      n_fail++;
      $display("FAIL end_cycle_dtack: got %b want 1", cpu_dtack_n);
    end
  endtask

  task automatic run_cycle(input logic [10:0] cs, input logic [10:0] cs_late, input int gap,
                           input int lat, input logic [3:0] region);
    exp_t e, got_e;
    int   ticks;
    bit   done;
    logic ce_v;
    e.lat = lat; e.region = region;
    sb.push_back(e);
    cs_n = cs; cpu_as_n = 1'b0; cpu_ds_n = 2'b00;
    clk_step(1'b1);
    ticks = 1;
    done  = (cpu_dtack_n === 1'b0);
    cs_n  = cs_late;
    for (int c = 0; c < 300 && !done; c++) begin
      ce_v = ((c % (gap + 1)) == gap);
      clk_step(ce_v);
      if (ce_v) ticks++;
      if (cpu_dtack_n === 1'b0) done = 1;
    end
    got_e = sb.pop_front();
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL cycle_latency cs=%h: DTACK never asserted, want after %0d ticks", cs, got_e.lat);
    end else if (ticks !== got_e.lat) begin
      n_fail++;
      $display("FAIL cycle_latency cs=%h: got %0d ticks want %0d", cs, ticks, got_e.lat);
    end
    n_checks++;
    if (active_region !== got_e.region) begin
      n_fail++;
      $display("FAIL cycle_region cs=%h: got %0d want %0d", cs, active_region, got_e.region);
    end
    end_cycle();
  endtask

  task automatic test_reset();
    n_checks++; if (cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL reset_dtack: got %b want 1", cpu_dtack_n); end
    n_checks++; if (cpu_berr_n !== 1'b1) begin n_fail++; $display("FAIL reset_berr: got %b want 1", cpu_berr_n); end
    n_checks++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL reset_rom_req: got %b want 0", rom_req); end
    n_checks++; if (active_region !== 4'd0) begin n_fail++; $display("FAIL reset_region: got %0d want 0", active_region); end
  endtask

  task automatic test_zero_wait();
    run_cycle(11'h7FE, 11'h7FE, 0, 1, 4'd0);
    run_cycle(11'h7F7, 11'h7F7, 2, 1, 4'd3);
  endtask

  task automatic test_waited();
    set_wait(2, 4'd3);
    // WORK drops mid-cycle; the latched SCREEN region must stay.
    run_cycle(11'h7FB, 11'h7FA, 5, 4, 4'd2);
    set_wait(5, 4'd1);
    run_cycle(11'h7DF, 11'h7DF, 1, 2, 4'd5);
  endtask

  task automatic test_rom();
    exp_t e, got_e;
    int   ticks;
    bit   seen;
    set_wait(1, 4'd2);
    e.lat = 3; e.region = 4'd1;
    sb.push_back(e);
    cs_n = 11'h7FD; cpu_as_n = 1'b0; cpu_ds_n = 2'b10;
    clk_step(1'b1);
    ticks = 1;
    seen  = (rom_req === 1'b1);
    for (int c = 0; c < 50 && !seen; c++) begin
      clk_step(c[0]);
      if (c[0]) ticks++;
      if (rom_req === 1'b1) seen = 1;
    end
    got_e = sb.pop_front();
    n_checks++;
    if (!seen || ticks !== got_e.lat) begin
      n_fail++;
      $display("FAIL rom_req_latency: got %0d ticks (seen=%0b) want %0d", ticks, seen, got_e.lat);
    end
    for (int c = 0; c < 10; c++) clk_step(c[0]);
    n_checks++; if (rom_req !== 1'b1) begin n_fail++; $display("FAIL rom_req_hold: got %b want 1", rom_req); end
    n_checks++; if (cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL rom_dtack_early: got %b want 1", cpu_dtack_n); end
    rom_ack = 1'b1;
    clk_step(1'b0);
    rom_ack = 1'b0;
    n_checks++; if (cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL rom_dtack_after_ack: got %b want 0", cpu_dtack_n); end
    n_checks++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL rom_req_after_ack: got %b want 0", rom_req); end
    n_checks++; if (active_region !== got_e.region) begin n_fail++; $display("FAIL rom_region: got %0d want %0d", active_region, got_e.region); end
    end_cycle();
  endtask

  task automatic test_abort();
    set_wait(1, 4'd0);
    cs_n = 11'h7FD; cpu_as_n = 1'b0; cpu_ds_n = 2'b00;
    clk_step(1'b1);
    n_checks++; if (rom_req !== 1'b1) begin n_fail++; $display("FAIL abort_ext_entry: got %b want 1", rom_req); end
    cpu_as_n = 1'b1;
    clk_step(1'b0);
    n_checks++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL abort_rom_req: got %b want 0", rom_req); end
    clk_step(1'b0);
    rom_ack = 1'b1;
    clk_step(1'b1);
    rom_ack = 1'b0;
    n_checks++; if (cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL late_ack_dtack: got %b want 1", cpu_dtack_n); end
    n_checks++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL late_ack_rom_req: got %b want 0", rom_req); end
    // rom_ack coincident with AS release: abort must win.
    cpu_as_n = 1'b0;
    clk_step(1'b1);
    cpu_as_n = 1'b1;
    rom_ack  = 1'b1;
    clk_step(1'b0);
    rom_ack  = 1'b0;
    n_checks++; if (cpu_dtack_n !== 1'b1 || rom_req !== 1'b0) begin
      n_fail++; $display("FAIL ack_as_race: got dtack_n=%b rom_req=%b want 1/0", cpu_dtack_n, rom_req);
    end
    clk_step(1'b1);
    n_checks++; if (cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL ack_as_race_after: got %b want 1", cpu_dtack_n); end
    end_cycle();
  endtask

  task automatic test_priority();
    set_wait(1, 4'd5);
    run_cycle(11'h7FC, 11'h7FC, 0, 1, 4'd0);
    // Both data strobes high: no cycle may start.
    cs_n = 11'h7F7; cpu_as_n = 1'b0; cpu_ds_n = 2'b11;
    for (int c = 0; c < 3; c++) clk_step(1'b1);
    n_checks++; if (cpu_dtack_n !== 1'b1 || active_region !== 4'd0) begin
      n_fail++; $display("FAIL ds_idle_no_start: got dtack_n=%b region=%0d want 1/0", cpu_dtack_n, active_region);
    end
    end_cycle();
`ifdef BUS_TIMEOUT_EN
    begin
      int  ticks;
      bit  seen;
      cs_n = '1; cpu_as_n = 1'b0; cpu_ds_n = 2'b00;
      clk_step(1'b1);
      ticks = 0;
      seen  = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
        clk_step(c[0]);
        if (c[0]) ticks++;
        if (cpu_berr_n === 1'b0) seen = 1;
      end
      n_checks++;
      if (!seen || ticks !== 16) begin
        n_fail++; $display("FAIL unmapped_berr: got %0d ticks (seen=%0b) want 16", ticks, seen);
      end
      n_checks++; if (cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL unmapped_dtack: got %b want 1", cpu_dtack_n); end
      end_cycle();
      n_checks++; if (cpu_berr_n !== 1'b1) begin n_fail++; $display("FAIL unmapped_berr_release: got %b want 1", cpu_berr_n); end
    end
`else
    run_cycle(11'h7FF, 11'h7FF, 0, 1, 4'd0);
    n_checks++; if (cpu_berr_n !== 1'b1) begin n_fail++; $display("FAIL unmapped_berr_tied: got %b want 1", cpu_berr_n); end
`endif
  endtask

  task automatic test_back_to_back();
    set_wait(3, 4'd1);
    run_cycle(11'h7FE, 11'h7FE, 0, 1, 4'd0);
    run_cycle(11'h7F7, 11'h7F7, 0, 2, 4'd3);
    run_cycle(11'h3FF, 11'h3FF, 3, 1, 4'd10);
  endtask

  task automatic async_reset_pulse();
    #2;
    reset = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    cpu_as_n = 1'b1; cpu_ds_n = 2'b11; cs_n = '1;
    @(negedge clk);
    reset = 1'b0;
    clk_step(1'b0);
  endtask

  task automatic test_reset_mid();
    set_wait(2, 4'd3);
    cs_n = 11'h7FB; cpu_as_n = 1'b0; cpu_ds_n = 2'b00;
    clk_step(1'b1);
    clk_step(1'b1);
    n_checks++; if (active_region !== 4'd2) begin n_fail++; $display("FAIL pre_reset_region: got %0d want 2", active_region); end
    async_reset_pulse();
    n_checks++; if (active_region !== 4'd0) begin n_fail++; $display("FAIL reset_wait_region: got %0d want 0", active_region); end
    n_checks++; if (cpu_dtack_n !== 1'b1 || rom_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_wait_outputs: got dtack_n=%b rom_req=%b want 1/0", cpu_dtack_n, rom_req);
    end
    release_reset();
    set_wait(1, 4'd0);
    cs_n = 11'h7FD; cpu_as_n = 1'b0; cpu_ds_n = 2'b00;
    clk_step(1'b1);
    async_reset_pulse();
    n_checks++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL reset_ext_rom_req: got %b want 0", rom_req); end
    release_reset();
    cs_n = 11'h7FE; cpu_as_n = 1'b0; cpu_ds_n = 2'b00;
    clk_step(1'b1);
    n_checks++; if (cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL pre_reset_ack: got %b want 0", cpu_dtack_n); end
    async_reset_pulse();
    n_checks++; if (cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL reset_ack_dtack: got %b want 1", cpu_dtack_n); end
    release_reset();
  endtask

  initial begin
    reset    = 1'b1;
    cpu_ce   = 1'b0;
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    cs_n     = '1;
    cfg_wait = '0;
    rom_ack  = 1'b0;
    #23;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    clk_step(1'b0);
    test_zero_wait();
    test_waited();
    test_rom();
    test_abort();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Responder end of the 68000 bus: consumes the per-region chip selects produced by the address decoder and drives DTACK/BERR back to the CPU.
- Inserts per-region wait states and runs the req/ack handshake with the SDRAM ROM port.
- Aborts cleanly when AS is released early.
- Sits between the CPU core, the address decoder and the memory arbiter in the Taito F2 top level.

Parameters:
- N_CS, 11, number of chip-select regions; index order is fixed by the shared package.
- WS_W, 4, width of each per-region wait-state field.
- TIMEOUT, 255, cpu_ce ticks before a bus error is raised; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_ce  in  1  CPU clock-enable; all counting and state advance only on cpu_ce=1
- cpu_as_n  in  1  CPU address strobe
- cpu_ds_n  in  2  CPU data strobes (UDS, LDS)
- cs_n  in  N_CS  active-low selects from the decoder; bit order per package enum
- cfg_wait  in  N_CS*WS_W  wait states per region, field i at [i*WS_W +: WS_W]
- rom_req  out  1  SDRAM ROM read request, level
- rom_ack  in  1  SDRAM completion, single-cycle pulse
- cpu_dtack_n  out  1  data acknowledge to CPU
- cpu_berr_n  out  1  bus error to CPU
- active_region  out  4  region index latched for the current cycle (debug/mux select)

Behaviour:
- Reset values: cpu_dtack_n=1, cpu_berr_n=1, rom_req=0, active_region=0, state=IDLE, wait counter=0.
- Reset is asynchronous and takes effect mid-cycle: all outputs return to reset values immediately.
- A cycle starts when cpu_ce=1, cpu_as_n=0 and cpu_ds_n!=2'b11.
- FSM states and transitions:
  - IDLE: on cycle start, latch the lowest asserted cs_n index into active_region and load the counter with that region's cfg_wait.
    - Next state is WAIT if cfg_wait>0, else EXT for ROM, else ACK.
    - If no cs_n is asserted, the region is unmapped (see Optional Feature).
  - WAIT: decrement on each cpu_ce. At 0, go to EXT for the ROM region, otherwise ACK.
  - EXT: rom_req=1. On rom_ack=1, drop rom_req on the next clk and go to ACK. rom_ack is ignored in every other state.
  - ACK: cpu_dtack_n=0. Hold until cpu_as_n=1, then go to IDLE and set cpu_dtack_n=1 on the same clk.
  - ERR: cpu_berr_n=0. Hold until cpu_as_n=1, then go to IDLE.
- Latency: a zero-wait non-ROM region asserts DTACK 1 cpu_ce tick after cycle start. Each wait state adds exactly 1 tick.
- Abort: cpu_as_n=1 in WAIT or EXT returns the FSM to IDLE within 1 clk and clears rom_req. A late rom_ack is discarded.
- Multiple cs_n asserted: the lowest index wins. This is not an error.
- cs_n changes after latch: ignored until the next cycle.
- rom_ack in the same clk that AS rises: the abort takes priority and DTACK is not asserted.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - A watchdog counts cpu_ce ticks in WAIT/EXT. On reaching TIMEOUT, go to ERR and drop rom_req.
  - Unmapped accesses go to ERR after TIMEOUT ticks.
- Undefined:
  - No watchdog.
  - Unmapped accesses go straight to ACK (open bus) after 1 tick.
  - cpu_berr_n is tied to 1.

Decomposition:
- Shared package (system_consts):
  - typedef enum of region indices (CS_WORK, CS_ROM, CS_SCREEN, CS_COLOR, CS_IO0, CS_IO1, CS_OBJECT, CS_SOUND, CS_PRIORITY, CS_EXTENSION, CS_CCHIP)
  - bus FSM state enum
  - constant CS_ROM_IDX
- One sub-module, cs_priority_encoder: combinational lowest-index-low finder with valid output. Everything else stays in this module.

Test Plan:
- Zero-wait region: WORK region (cs_n[0]=0), cfg_wait=0, AS low → DTACK low 1 cpu_ce tick later; DTACK high the clk after AS rises.
- Waited region: SCREEN region, cfg_wait=3 → DTACK asserts on the 4th cpu_ce tick after start. Verify counter stalls when cpu_ce=0 for 5 clks.
- ROM region: ROM region, cfg_wait=2 → rom_req rises after 2 ticks. Hold rom_ack off for 10 clks, then pulse it → DTACK the next clk and rom_req low.
- Abort: AS released while in EXT → rom_req low within 1 clk, no DTACK. A rom_ack 2 clks later is ignored and the FSM stays IDLE.
- Priority and unmapped: cs_n=0x7FC (bits 0,1 low) → active_region=0. With cs_n all high, no macro → DTACK after 1 tick. With BUS_TIMEOUT_EN and TIMEOUT=16 → BERR low after 16 ticks.
- Reset in WAIT: assert reset asynchronously mid-wait → cpu_dtack_n=1, rom_req=0, active_region=0 without waiting for a clk edge.
